// File: rtl/i2c_write_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_write_sequencer
//
// Command source for a single-byte I2C master. Holds a table of
// (7-bit slave address, data byte) entries and replays the first L of them as
// back-to-back single-byte write transactions. Typical use is power-up register
// initialisation of an I2C peripheral.
//
// Each entry is issued with a one-cycle o_write_start pulse. The sequencer then
// waits for the master to raise busy, waits for busy to fall, and re-issues the
// entry on master error, up to MAX_RETRIES times. A fixed idle gap separates
// consecutive transactions. If the master stays in one phase for too long, the
// sequence is aborted with a timeout code.
//
// Ports
//   i_clk            clock, all logic on rising edge
//   i_rst            synchronous active-high reset
//   i_tbl_wr_en      table write strobe (dropped while o_seq_busy)
//   i_tbl_wr_idx     table write index
//   i_tbl_wr_addr    slave address for the entry
//   i_tbl_wr_data    data byte for the entry
//   i_seq_len        number of entries to run, sampled on accepted i_go
//   i_go             start pulse, accepted only while idle
//   o_seq_busy       high from accepted i_go until o_seq_done
//   o_seq_done       one-cycle completion pulse
//   o_err_code       0 ok, 1 retries exhausted, 2 timeout (held until next go)
//   o_fail_idx       index of the failing entry, 0 when o_err_code is 0
//   o_slave_addr     to master i_slave_addr
//   o_wr_byte        to master i_wr_byte
//   o_write_start    to master i_write_start, one-cycle pulse
//   i_master_busy    from master o_busy
//   i_master_error   from master o_error
// -----------------------------------------------------------------------------
module i2c_write_sequencer #(
  parameter int NUM_ENTRIES  = 16,
  parameter int GAP_CYCLES   = 100,
  parameter int MAX_RETRIES  = 2,
  parameter int BUSY_TIMEOUT = 65535,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tbl_wr_en,
  input  logic [IDX_W-1:0] i_tbl_wr_idx,
  input  logic [6:0]       i_tbl_wr_addr,
  input  logic [7:0]       i_tbl_wr_data,
  input  logic [IDX_W:0]   i_seq_len,
  input  logic             i_go,
  output logic             o_seq_busy,
  output logic             o_seq_done,
  output logic [1:0]       o_err_code,
  output logic [IDX_W-1:0] o_fail_idx,
  output logic [6:0]       o_slave_addr,
  output logic [7:0]       o_wr_byte,
  output logic             o_write_start,
  input  logic             i_master_busy,
  input  logic             i_master_error
);

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int LEN_W = IDX_W + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [LEN_W-1:0] NUM_L     = LEN_W'(NUM_ENTRIES);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(BUSY_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRIES);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_RETRIES = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACCEPT,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH
  } state_e;

  // ---------------------------------------------------------------------------
  // Command table: {addr[6:0], data[7:0]} per entry
  // ---------------------------------------------------------------------------
  logic [14:0] tbl_q [NUM_ENTRIES];
  logic        busy_q;
  logic        tbl_wr_ok;

  // Writes are dropped while a sequence runs so the replayed contents cannot
  // change under the sequencer. The index guard matters for non power-of-two
  // depths.
  assign tbl_wr_ok = i_tbl_wr_en && !busy_q && (int'(i_tbl_wr_idx) < NUM_ENTRIES);

  // NOTE: the table has no reset on purpose. Contents must survive a mid-run
  // reset, and leaving a storage array out of reset keeps it mappable to plain
  // flops/RAM without a reset fan-out to every bit.
  always_ff @(posedge i_clk) begin
    if (tbl_wr_ok) begin
      tbl_q[i_tbl_wr_idx] <= {i_tbl_wr_addr, i_tbl_wr_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [LEN_W-1:0] len_q;
  logic [RTY_W-1:0] retry_q;
  logic [GAP_W-1:0] gap_q;
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
  logic             done_q;
  logic [1:0]       code_q;
  logic [IDX_W-1:0] fail_q;
  logic [6:0]       addr_q;
  logic [7:0]       byte_q;
  logic             start_q;

  logic [LEN_W-1:0] seq_len_eff;
  logic [14:0]      tbl_rd;
  logic             err_now;
  logic             last_entry;

  // Effective length is clamped to the table depth.
  assign seq_len_eff = (i_seq_len > NUM_L) ? NUM_L : i_seq_len;
  assign tbl_rd      = tbl_q[idx_q];

  // An error reported in the same cycle busy falls still counts.
  assign err_now    = err_q | i_master_error;
  assign last_entry = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      retry_q <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      code_q  <= ERR_OK;
      fail_q  <= '0;
      addr_q  <= '0;
      byte_q  <= '0;
      start_q <= 1'b0;
    end else begin
      // Pulse outputs default low; only ISSUE/FINISH raise them.
      start_q <= 1'b0;
      done_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (i_go) begin
            busy_q  <= 1'b1;
            code_q  <= ERR_OK;
            fail_q  <= '0;
            len_q   <= seq_len_eff;
            idx_q   <= '0;
            retry_q <= '0;
            err_q   <= 1'b0;
            state_q <= (seq_len_eff == '0) ? S_FINISH : S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Address and data stay stable until the next ISSUE.
          addr_q  <= tbl_rd[14:8];
          byte_q  <= tbl_rd[7:0];
          start_q <= 1'b1;
          tmo_q   <= '0;
          state_q <= S_WAIT_ACCEPT;
        end

        S_WAIT_ACCEPT: begin
          if (i_master_busy) begin
            tmo_q   <= '0;
            state_q <= S_WAIT_DONE;
          end else if (tmo_q == TMO_LAST) begin
            code_q  <= ERR_TIMEOUT;
            fail_q  <= idx_q;
            state_q <= S_FINISH;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        S_WAIT_DONE: begin
          err_q <= err_now;
          if (!i_master_busy) begin
            gap_q <= '0;
            if (err_now) begin
              if (retry_q < RTY_LIMIT) begin
                // Same entry again after the gap.
                retry_q <= retry_q + RTY_W'(1);
                state_q <= S_GAP;
              end else begin
                code_q  <= ERR_RETRIES;
                fail_q  <= idx_q;
                state_q <= S_FINISH;
              end
            end else if (last_entry) begin
              state_q <= S_FINISH;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              retry_q <= '0;
              state_q <= S_GAP;
            end
          end else if (tmo_q == TMO_LAST) begin
            code_q  <= ERR_TIMEOUT;
            fail_q  <= idx_q;
            state_q <= S_FINISH;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            err_q   <= 1'b0;
            state_q <= S_ISSUE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        S_FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign o_seq_busy    = busy_q;
  assign o_seq_done    = done_q;
  assign o_err_code    = code_q;
  assign o_fail_idx    = fail_q;
  assign o_slave_addr  = addr_q;
  assign o_wr_byte     = byte_q;
  assign o_write_start = start_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2c_write_sequencer
//
// Directed bench for i2c_write_sequencer. Stimulus pushes the expected write
// transactions and completion results into queues; a monitor pops and compares
// whenever the DUT pulses o_write_start or o_seq_done. A small master model
// answers each write_start with a busy window and optional error.
// -----------------------------------------------------------------------------
module tb_i2c_write_sequencer;

  localparam int NUM_ENTRIES  = 16;
  localparam int GAP_CYCLES   = 5;
  localparam int MAX_RETRIES  = 2;
  localparam int BUSY_TIMEOUT = 200;
  localparam int IDX_W        = 4;
  localparam int BUSY_LEN     = 40;
  localparam int MIN_SPACING  = BUSY_LEN + GAP_CYCLES + 2;

  logic             clk = 1'b0;
  logic             i_rst;
  logic             i_tbl_wr_en;
  logic [IDX_W-1:0] i_tbl_wr_idx;
  logic [6:0]       i_tbl_wr_addr;
  logic [7:0]       i_tbl_wr_data;
  logic [IDX_W:0]   i_seq_len;
  logic             i_go;
  logic             o_seq_busy;
  logic             o_seq_done;
  logic [1:0]       o_err_code;
  logic [IDX_W-1:0] o_fail_idx;
  logic [6:0]       o_slave_addr;
  logic [7:0]       o_wr_byte;
  logic             o_write_start;
  logic             m_busy;
  logic             m_err;

  always #5 clk = ~clk;

  i2c_write_sequencer #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .GAP_CYCLES  (GAP_CYCLES),
    .MAX_RETRIES (MAX_RETRIES),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_tbl_wr_en   (i_tbl_wr_en),
    .i_tbl_wr_idx  (i_tbl_wr_idx),
    .i_tbl_wr_addr (i_tbl_wr_addr),
    .i_tbl_wr_data (i_tbl_wr_data),
    .i_seq_len     (i_seq_len),
    .i_go          (i_go),
    .o_seq_busy    (o_seq_busy),
    .o_seq_done    (o_seq_done),
    .o_err_code    (o_err_code),
    .o_fail_idx    (o_fail_idx),
    .o_slave_addr  (o_slave_addr),
    .o_wr_byte     (o_wr_byte),
    .o_write_start (o_write_start),
    .i_master_busy (m_busy),
    .i_master_error(m_err)
  );

  typedef struct packed { logic [6:0] addr; logic [7:0] data; } tx_t;
  typedef struct packed { logic [1:0] code; logic [IDX_W-1:0] idx; } done_t;

  tx_t   exp_tx[$];
  done_t exp_done[$];
  tx_t   tbl_model [NUM_ENTRIES];
  tx_t   et;
  done_t ed;

  int n_cmp   = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_ws    = 0;
  int cyc     = 0;
  int last_ws = -1;

  // Master model controls: 0 no error, 1 error on first hit of target only,
  // 2 error on every hit of target. Target is entry 1 (0x50/0xB2).
  int err_mode = 0;
  int m_hits   = 0;
  bit no_busy  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Master model: busy rises one clock after write_start, stays high BUSY_LEN
  // clocks; a programmed error appears in the same cycle busy falls.
  // ---------------------------------------------------------------------------
  initial begin
    int  m_cnt;
    bit  m_seen;
    bit  m_err_pend;
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
    m_seen = 1'b0;
    m_err_pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_err = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_err  = m_err_pend;
        end
      end
      if (m_seen) begin
        m_seen = 1'b0;
        if (!no_busy) begin
          m_busy = 1'b1;
          m_cnt  = BUSY_LEN;
        end
      end
      if (o_write_start) begin
        m_seen = 1'b1;
        m_err_pend = 1'b0;
        if (o_slave_addr == 7'h50 && o_wr_byte == 8'hB2) begin
          m_err_pend = (err_mode == 2) || (err_mode == 1 && m_hits == 0);
          m_hits++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (o_write_start) begin
        n_ws++;
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected write_start: got addr 0x%0h data 0x%0h, none expected",
                   o_slave_addr, o_wr_byte);
        end else begin
          et = exp_tx.pop_front();
          check("write_start addr/data", {17'b0, o_slave_addr, o_wr_byte}, {17'b0, et});
        end
        if (last_ws >= 0) begin
          n_cmp++;
          if (cyc - last_ws < MIN_SPACING) begin
            n_fail++;
            $display("FAIL write_start spacing: got %0d cycles required >= %0d",
                     cyc - last_ws, MIN_SPACING);
          end
        end
        last_ws = cyc;
      end
      if (o_seq_done) begin
        n_done++;
        last_ws = -1;
        if (exp_done.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected seq_done: got code %0d fail_idx %0d, none expected",
                   o_err_code, o_fail_idx);
        end else begin
          ed = exp_done.pop_front();
          check("seq_done code/fail_idx", {26'b0, o_err_code, o_fail_idx}, {26'b0, ed});
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int i, input logic [6:0] a, input logic [7:0] d);
    i_tbl_wr_en   = 1'b1;
    i_tbl_wr_idx  = IDX_W'(i);
    i_tbl_wr_addr = a;
    i_tbl_wr_data = d;
    tick();
    i_tbl_wr_en   = 1'b0;
    tbl_model[i]  = {a, d};
  endtask

  task automatic push_tx(input int i);
    exp_tx.push_back(tbl_model[i]);
  endtask

  task automatic push_done(input logic [1:0] c, input int i);
    exp_done.push_back({c, IDX_W'(i)});
  endtask

  task automatic go(input int len);
    i_seq_len = (IDX_W+1)'(len);
    i_go      = 1'b1;
    tick();
    i_go      = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output int cycles);
    cycles = 0;
    while (n_done < target && cycles < budget) begin
      tick();
      cycles++;
    end
    if (n_done < target) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_done: got %0d done pulses after %0d cycles, required %0d",
               n_done, cycles, target);
    end
  endtask

  task automatic drained(input string name);
    repeat (5) tick();
    check({name, " tx queue drained"}, exp_tx.size(), 0);
    check({name, " done queue drained"}, exp_done.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int tgt;
    int cycles;
    int ws0;
    int d0;

    i_rst = 1'b1;
    i_tbl_wr_en = 1'b0;
    i_tbl_wr_idx = '0;
    i_tbl_wr_addr = '0;
    i_tbl_wr_data = '0;
    i_seq_len = '0;
    i_go = 1'b0;
    repeat (3) tick();
    check("reset outputs",
          {8'b0, o_seq_busy, o_seq_done, o_err_code, o_fail_idx, o_slave_addr, o_wr_byte,
           o_write_start}, 32'h0);
    i_rst = 1'b0;
    tick();

    for (int i = 0; i < NUM_ENTRIES; i++) load(i, 7'(16 + i), 8'(192 + i));
    load(0, 7'h50, 8'hA1);
    load(1, 7'h50, 8'hB2);
    load(2, 7'h3C, 8'h00);

    // Basic three-entry run.
    push_tx(0); push_tx(1); push_tx(2);
    push_done(2'd0, 0);
    tgt = n_done + 1;
    go(3);
    wait_done(tgt, 2000, cycles);
    drained("len3");

    // Zero length: done one cycle after busy, no write_start.
    ws0 = n_ws;
    push_done(2'd0, 0);
    i_seq_len = '0;
    i_go = 1'b1;
    tick();
    i_go = 1'b0;
    check("len0 busy/done at T+1", {30'b0, o_seq_busy, o_seq_done}, 32'b10);
    tick();
    check("len0 busy/done/code at T+2", {28'b0, o_seq_busy, o_seq_done, o_err_code}, 32'b0100);
    drained("len0");
    check("len0 write_start count", n_ws - ws0, 0);

    // Length clamped to table depth.
    for (int i = 0; i < NUM_ENTRIES; i++) push_tx(i);
    push_done(2'd0, 0);
    ws0 = n_ws;
    tgt = n_done + 1;
    go(20);
    wait_done(tgt, 5000, cycles);
    drained("len20");
    check("len20 write_start count", n_ws - ws0, NUM_ENTRIES);

    // Single error on entry 1 is recovered by one retry.
    err_mode = 1;
    m_hits = 0;
    push_tx(0); push_tx(1); push_tx(1); push_tx(2);
    push_done(2'd0, 0);
    tgt = n_done + 1;
    go(3);
    wait_done(tgt, 3000, cycles);
    drained("retry_once");

    // Persistent error on entry 1 exhausts retries.
    err_mode = 2;
    m_hits = 0;
    push_tx(0);
    for (int r = 0; r <= MAX_RETRIES; r++) push_tx(1);
    push_done(2'd1, 1);
    tgt = n_done + 1;
    go(3);
    wait_done(tgt, 3000, cycles);
    drained("retry_exhaust");
    err_mode = 0;

    // Master never accepts: timeout on entry 0.
    no_busy = 1'b1;
    push_tx(0);
    push_done(2'd2, 0);
    tgt = n_done + 1;
    go(2);
    wait_done(tgt, BUSY_TIMEOUT + 50, cycles);
    n_cmp++;
    if (cycles < BUSY_TIMEOUT || cycles > BUSY_TIMEOUT + 10) begin
      n_fail++;
      $display("FAIL timeout latency: got %0d cycles required %0d..%0d",
               cycles, BUSY_TIMEOUT, BUSY_TIMEOUT + 10);
    end
    drained("timeout");
    no_busy = 1'b0;

    // go and table write during a running sequence are ignored.
    push_tx(0); push_tx(1); push_tx(2);
    push_done(2'd0, 0);
    tgt = n_done + 1;
    go(3);
    repeat (60) tick();
    i_seq_len     = 5'd1;
    i_go          = 1'b1;
    i_tbl_wr_en   = 1'b1;
    i_tbl_wr_idx  = '0;
    i_tbl_wr_addr = 7'h7F;
    i_tbl_wr_data = 8'hFF;
    tick();
    i_go        = 1'b0;
    i_tbl_wr_en = 1'b0;
    wait_done(tgt, 2000, cycles);
    repeat (20) tick();
    check("busy-time go ignored: done count", n_done, tgt);
    drained("busy_ignore");
    push_tx(0);
    push_done(2'd0, 0);
    tgt = n_done + 1;
    go(1);
    wait_done(tgt, 500, cycles);
    drained("table_unchanged");

    // Reset during WAIT_DONE: outputs clear, no done, table preserved.
    push_tx(0);
    ws0 = n_ws;
    go(3);
    for (int i = 0; i < 20 && n_ws == ws0; i++) tick();
    repeat (10) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    last_ws = -1;
    check("mid-run reset outputs",
          {8'b0, o_seq_busy, o_seq_done, o_err_code, o_fail_idx, o_slave_addr, o_wr_byte,
           o_write_start}, 32'h0);
    d0 = n_done;
    repeat (100) tick();
    check("mid-run reset: no done pulse", n_done, d0);
    drained("reset_abort");
    push_tx(0); push_tx(1); push_tx(2);
    push_done(2'd0, 0);
    tgt = n_done + 1;
    go(3);
    wait_done(tgt, 2000, cycles);
    drained("rerun_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
